// File: rtl/accumulator_8bit.sv
// accumulator_8bit
//   Multi-operand summing stage. Accepts N_OPERANDS unsigned 8-bit operands
//   over a valid/ready handshake. It sums them into an 8-bit accumulator with
//   a sticky carry flag, then presents the total on an output handshake.
//
//   Optional feature macro: SATURATE_EN
//     defined   : any carrying addition loads the accumulator with 0xFF
//     undefined : wrap-around modulo 256
//
// Ports:
//   Clk      in   rising-edge clock
//   Rst_n    in   asynchronous active-low reset
//   Start    in   begin a run (honoured only in IDLE)
//   InValid  in   InData holds an operand
//   InReady  out  operand accepted this cycle (ACCUM)
//   InData   in   8-bit unsigned operand
//   OutValid out  final result available (DONE)
//   OutReady in   consumer takes the result
//   OutSum   out  live accumulator value
//   OutCarry out  sticky carry out of bit 7
//   Busy     out  any state other than IDLE
module accumulator_8bit #(
    parameter int N_OPERANDS = 4
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Start,
    input  logic       InValid,
    output logic       InReady,
    input  logic [7:0] InData,
    output logic       OutValid,
    input  logic       OutReady,
    output logic [7:0] OutSum,
    output logic       OutCarry,
    output logic       Busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] LAST_COUNT = 8'(N_OPERANDS);

    state_t     state, state_next;
    logic [7:0] acc, acc_next;
    logic [7:0] count, count_next;
    logic       carry, carry_next;
    logic [8:0] sum9;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            carry <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            count <= count_next;
            carry <= carry_next;
        end
    end

    always_comb begin
        state_next = state;
        acc_next   = acc;
        count_next = count;
        carry_next = carry;
        sum9       = {1'b0, acc} + {1'b0, InData};

        unique case (state)
            IDLE: begin
                if (Start) begin
                    acc_next   = '0;
                    count_next = '0;
                    carry_next = 1'b0;
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                if (InValid) begin
`ifdef SATURATE_EN
                    // Once at 0xFF every further non-zero add carries again,
                    // so saturation persists for the rest of the run.
                    acc_next = sum9[8] ? 8'hFF : sum9[7:0];
`else
                    acc_next = sum9[7:0];
`endif
                    carry_next = carry | sum9[8];
                    count_next = count + 8'd1;
                    if (count + 8'd1 == LAST_COUNT) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (OutReady) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // All outputs decode from registered state only.
    assign InReady  = (state == ACCUM);
    assign OutValid = (state == DONE);
    assign Busy     = (state != IDLE);
    assign OutSum   = acc;
    assign OutCarry = carry;

endmodule

// File: tb/tb_accumulator_8bit.sv
// Self-checking bench for accumulator_8bit: a vector table, hand-written
// corner sequences (reset mid-run, single operand), and randomized runs
// checked against a plain-arithmetic reference model.
module tb_accumulator_8bit;

    logic       Clk;
    logic       Rst_n;
    logic       Start, InValid, OutReady;
    logic [7:0] InData;
    logic       InReady, OutValid, OutCarry, Busy;
    logic [7:0] OutSum;

    logic       s_Start, s_InValid, s_OutReady;
    logic [7:0] s_InData;
    logic       s_InReady, s_OutValid, s_OutCarry, s_Busy;
    logic [7:0] s_OutSum;

    int total = 0;
    int bad   = 0;

    accumulator_8bit #(.N_OPERANDS(4)) u0 (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .InValid(InValid),
        .InReady(InReady), .InData(InData), .OutValid(OutValid),
        .OutReady(OutReady), .OutSum(OutSum), .OutCarry(OutCarry), .Busy(Busy)
    );

    accumulator_8bit #(.N_OPERANDS(1)) u1 (
        .Clk(Clk), .Rst_n(Rst_n), .Start(s_Start), .InValid(s_InValid),
        .InReady(s_InReady), .InData(s_InData), .OutValid(s_OutValid),
        .OutReady(s_OutReady), .OutSum(s_OutSum), .OutCarry(s_OutCarry),
        .Busy(s_Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        string           name;
        logic [3:0][7:0] ops;
        int              gaps[4];
        int              bp;
        logic [7:0]      exp_sum;
        logic            exp_carry;
    } vec_t;

    vec_t vecs[5];

    // Reference model state for the run in progress.
    logic [7:0] m_acc;
    logic       m_carry;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: act=0x%0h req=0x%0h", name, act, req);
        end
    endtask

    function automatic void model_add(input logic [7:0] op);
        int t;
        t = int'(m_acc) + int'(op);
        if (t > 255) begin
            m_carry = 1'b1;
`ifdef SATURATE_EN
            m_acc = 8'hFF;
`else
            m_acc = 8'(t - 256);
`endif
        end else begin
            m_acc = 8'(t);
        end
    endfunction

    task automatic start_run();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        m_acc   = 8'h00;
        m_carry = 1'b0;
        chk("start_inready", int'(InReady), 1);
        chk("start_busy", int'(Busy), 1);
        chk("start_sum_clear", int'(OutSum), 0);
    endtask

    // Inserts gap bubble cycles (with garbage data), then one transfer.
    task automatic feed(input logic [7:0] op, input int gap, input bit last);
        for (int g = 0; g < gap; g++) begin
            InValid = 1'b0;
            InData  = 8'($urandom);
            @(negedge Clk);
            chk("bubble_hold", int'(OutSum), int'(m_acc));
            chk("bubble_inready", int'(InReady), 1);
        end
        InValid = 1'b1;
        InData  = op;
        @(negedge Clk);
        InValid = 1'b0;
        model_add(op);
        chk("xfer_sum", int'(OutSum), int'(m_acc));
        chk("xfer_outvalid", int'(OutValid), last ? 1 : 0);
    endtask

    task automatic finish_run(input logic [7:0] es, input logic ec, input int bp);
        chk("result_sum", int'(OutSum), int'(es));
        chk("result_carry", int'(OutCarry), int'(ec));
        for (int b = 0; b < bp; b++) begin
            Start   = 1'b1;
            InValid = 1'b1;
            InData  = 8'($urandom);
            @(negedge Clk);
            chk("bp_outvalid", int'(OutValid), 1);
            chk("bp_inready", int'(InReady), 0);
            chk("bp_sum", int'(OutSum), int'(es));
            chk("bp_carry", int'(OutCarry), int'(ec));
        end
        Start    = 1'b0;
        InValid  = 1'b0;
        OutReady = 1'b1;
        @(negedge Clk);
        OutReady = 1'b0;
        chk("accept_busy", int'(Busy), 0);
        chk("accept_outvalid", int'(OutValid), 0);
        chk("accept_inready", int'(InReady), 0);
    endtask

    initial begin
        vecs[0] = '{"basic", {8'h40, 8'h30, 8'h20, 8'h10}, '{0, 0, 0, 0}, 0, 8'hA0, 1'b0};
`ifdef SATURATE_EN
        vecs[1] = '{"overflow", {8'h00, 8'h00, 8'h67, 8'hCA}, '{0, 0, 0, 0}, 0, 8'hFF, 1'b1};
        vecs[4] = '{"all_ff", {8'hFF, 8'hFF, 8'hFF, 8'hFF}, '{0, 1, 0, 0}, 1, 8'hFF, 1'b1};
`else
        vecs[1] = '{"overflow", {8'h00, 8'h00, 8'h67, 8'hCA}, '{0, 0, 0, 0}, 0, 8'h31, 1'b1};
        vecs[4] = '{"all_ff", {8'hFF, 8'hFF, 8'hFF, 8'hFF}, '{0, 1, 0, 0}, 1, 8'hFC, 1'b1};
`endif
        // InValid pattern 1,0,0,1,0,1,1
        vecs[2] = '{"bubbles", {8'h04, 8'h03, 8'h02, 8'h01}, '{0, 2, 1, 0}, 0, 8'h0A, 1'b0};
        vecs[3] = '{"backpressure", {8'h00, 8'h00, 8'h00, 8'h00}, '{0, 0, 0, 0}, 5, 8'h00, 1'b0};

        Rst_n = 1'b0; Start = 1'b0; InValid = 1'b0; InData = 8'h00; OutReady = 1'b0;
        s_Start = 1'b0; s_InValid = 1'b0; s_InData = 8'h00; s_OutReady = 1'b0;
        repeat (2) @(negedge Clk);
        chk("reset_sum", int'(OutSum), 0);
        chk("reset_carry", int'(OutCarry), 0);
        chk("reset_inready", int'(InReady), 0);
        chk("reset_outvalid", int'(OutValid), 0);
        chk("reset_busy", int'(Busy), 0);
        Rst_n = 1'b1;
        @(negedge Clk);
        chk("idle_busy", int'(Busy), 0);

        for (int v = 0; v < 5; v++) begin
            start_run();
            for (int i = 0; i < 4; i++) feed(vecs[v].ops[i], vecs[v].gaps[i], i == 3);
            finish_run(vecs[v].exp_sum, vecs[v].exp_carry, vecs[v].bp);
        end

        // Reset mid-run after two operands; asynchronous, so checked before any edge.
        start_run();
        feed(8'hF0, 0, 1'b0);
        feed(8'hF0, 0, 1'b0);
        #1 Rst_n = 1'b0;
        #1;
        chk("midrst_sum", int'(OutSum), 0);
        chk("midrst_carry", int'(OutCarry), 0);
        chk("midrst_inready", int'(InReady), 0);
        chk("midrst_outvalid", int'(OutValid), 0);
        chk("midrst_busy", int'(Busy), 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        start_run();
        for (int i = 0; i < 4; i++) feed(8'h05, 0, i == 3);
        finish_run(8'h14, 1'b0, 0);

        // Single-operand instance.
        s_Start = 1'b1;
        @(negedge Clk);
        s_Start = 1'b0;
        chk("single_inready", int'(s_InReady), 1);
        s_InValid = 1'b1;
        s_InData  = 8'hFF;
        @(negedge Clk);
        s_InValid = 1'b0;
        chk("single_outvalid", int'(s_OutValid), 1);
        chk("single_sum", int'(s_OutSum), 8'hFF);
        chk("single_carry", int'(s_OutCarry), 0);
        s_OutReady = 1'b1;
        @(negedge Clk);
        s_OutReady = 1'b0;
        chk("single_idle", int'(s_Busy), 0);

        // Randomized runs against the reference model.
        for (int r = 0; r < 40; r++) begin
            logic [7:0] ops[4];
            int gaps[4];
            start_run();
            for (int i = 0; i < 4; i++) begin
                ops[i]  = (r % 3 == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom);
                gaps[i] = $urandom_range(0, 2);
                feed(ops[i], gaps[i], i == 3);
            end
            finish_run(m_acc, m_carry, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
